// File: rtl/vga_sync_if.sv
// Timing bundle produced by the VGA sync generator: sync strobes, visibility,
// pixel/line/frame ticks and the current raster position.
interface vga_sync_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic       line_tick;
    logic       frame_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;

    modport master (
        output hsync,
        output vsync,
        output video_on,
        output p_tick,
        output line_tick,
        output frame_tick,
        output pixel_x,
        output pixel_y
    );

    modport slave (
        input hsync,
        input vsync,
        input video_on,
        input p_tick,
        input line_tick,
        input frame_tick,
        input pixel_x,
        input pixel_y
    );
endinterface

// File: rtl/vga_sync.sv
// VGA raster timing generator: divides the system clock down to a pixel strobe
// and walks a pixel_x/pixel_y raster with registered sync and blanking outputs.
module vga_sync #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic      clk,
    input  logic      reset,
    vga_sync_if.master vga
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned DIV_W    = 4;
    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_FIRST = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_LAST  = H_DISPLAY + H_FRONT + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_LAST  = V_DISPLAY + V_FRONT + V_SYNC - 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] x_q;
    logic [CNT_W-1:0] y_q;
    logic [CNT_W-1:0] x_d;
    logic [CNT_W-1:0] y_d;
    logic             hsync_q;
    logic             vsync_q;
    logic             video_on_q;

    logic             p_tick_c;
    logic             line_end_c;
    logic             frame_end_c;
    logic             hsync_d;
    logic             vsync_d;
    logic             video_on_d;

    // Strobes are pure decodes of registered state, one clk wide by construction.
    always_comb begin
        p_tick_c    = (div_q == DIV_LAST);
        line_end_c  = p_tick_c && (x_q == X_LAST);
        frame_end_c = line_end_c && (y_q == Y_LAST);
    end

    // Next raster position; counters only move on a pixel strobe.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (p_tick_c) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + CNT_W'(1);
                end
            end else begin
                x_d = x_q + CNT_W'(1);
            end
        end
    end

    // Sync/blank decoded from the next position so they land with the counters.
    always_comb begin
        hsync_d    = !((x_d >= CNT_W'(HS_FIRST)) && (x_d <= CNT_W'(HS_LAST)));
        vsync_d    = !((y_d >= CNT_W'(VS_FIRST)) && (y_d <= CNT_W'(VS_LAST)));
        video_on_d = (x_d < CNT_W'(H_DISPLAY)) && (y_d < CNT_W'(V_DISPLAY));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b1;
        end else begin
            div_q      <= p_tick_c ? '0 : div_q + DIV_W'(1);
            x_q        <= x_d;
            y_q        <= y_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.video_on   = video_on_q;
    assign vga.p_tick     = p_tick_c;
    assign vga.line_tick  = line_end_c;
    assign vga.frame_tick = frame_end_c;
    assign vga.pixel_x    = x_q;
    assign vga.pixel_y    = y_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default-geometry instance and a reduced-geometry
// instance checked every clk against an arithmetic raster model.
module tb_vga_sync;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       pt;
        logic       lt;
        logic       ft;
        logic       hs;
        logic       vs;
        logic       von;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    int checks = 0;
    int errors = 0;

    longint na = 0;
    longint nb = 0;
    logic       prev_ok_a = 1'b0;
    logic       prev_ok_b = 1'b0;
    logic [9:0] px_a, py_a, px_b, py_b;
    logic       phs_a, pvs_a, phs_b, pvs_b;

    vga_sync_if va ();
    vga_sync_if vb ();

    vga_sync dut_a (
        .clk   (clk),
        .reset (rst_a),
        .vga   (va)
    );

    vga_sync #(
        .CLK_DIV   (2),
        .H_DISPLAY (8),
        .H_FRONT   (2),
        .H_SYNC    (2),
        .H_BACK    (2),
        .V_DISPLAY (4),
        .V_FRONT   (1),
        .V_SYNC    (1),
        .V_BACK    (1)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .vga   (vb)
    );

    always #5 clk = ~clk;

    // Raster position after n rising edges since reset release, from arithmetic alone.
    function automatic exp_t model(longint n, longint div, longint hd, longint hf, longint hsw,
                                   longint hb, longint vd, longint vf, longint vsw, longint vb_);
        exp_t   e;
        longint ht  = hd + hf + hsw + hb;
        longint vt  = vd + vf + vsw + vb_;
        longint idx = n / div;
        longint x   = idx % ht;
        longint y   = (idx / ht) % vt;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.pt  = ((n % div) == div - 1);
        e.lt  = e.pt && (x == ht - 1);
        e.ft  = e.lt && (y == vt - 1);
        e.hs  = !((x >= hd + hf) && (x < hd + hf + hsw));
        e.vs  = !((y >= vd + vf) && (y < vd + vf + vsw));
        e.von = (x < hd) && (y < vd);
        return e;
    endfunction

    task automatic chk1(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk10(string tag, logic [9:0] obs, logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_int(string tag, int obs, int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_a(string p);
        exp_t e = model(na, 4, 640, 16, 96, 48, 480, 10, 2, 33);
        chk10({p, "_a_x"}, va.pixel_x, e.x);
        chk10({p, "_a_y"}, va.pixel_y, e.y);
        chk1({p, "_a_ptick"}, va.p_tick, e.pt);
        chk1({p, "_a_ltick"}, va.line_tick, e.lt);
        chk1({p, "_a_ftick"}, va.frame_tick, e.ft);
        chk1({p, "_a_hsync"}, va.hsync, e.hs);
        chk1({p, "_a_vsync"}, va.vsync, e.vs);
        chk1({p, "_a_von"}, va.video_on, e.von);
        chk1({p, "_a_range"}, (va.pixel_x < 10'd800) && (va.pixel_y < 10'd525), 1'b1);
    endtask

    task automatic check_b(string p);
        exp_t e = model(nb, 2, 8, 2, 2, 2, 4, 1, 1, 1);
        chk10({p, "_b_x"}, vb.pixel_x, e.x);
        chk10({p, "_b_y"}, vb.pixel_y, e.y);
        chk1({p, "_b_ptick"}, vb.p_tick, e.pt);
        chk1({p, "_b_ltick"}, vb.line_tick, e.lt);
        chk1({p, "_b_ftick"}, vb.frame_tick, e.ft);
        chk1({p, "_b_hsync"}, vb.hsync, e.hs);
        chk1({p, "_b_vsync"}, vb.vsync, e.vs);
        chk1({p, "_b_von"}, vb.video_on, e.von);
    endtask

    // One clk: count edges outside reset, then check both instances on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_a) na++;
        if (!rst_b) nb++;
        @(negedge clk);
        check_a("cyc");
        check_b("cyc");
        if (prev_ok_a) begin
            chk1("a_hs_stable", (va.hsync != phs_a) && (va.pixel_x == px_a), 1'b0);
            chk1("a_vs_stable", (va.vsync != pvs_a) && (va.pixel_y == py_a), 1'b0);
        end
        if (prev_ok_b) begin
            chk1("b_hs_stable", (vb.hsync != phs_b) && (vb.pixel_x == px_b), 1'b0);
            chk1("b_vs_stable", (vb.vsync != pvs_b) && (vb.pixel_y == py_b), 1'b0);
        end
        prev_ok_a = !rst_a;
        prev_ok_b = !rst_b;
        px_a = va.pixel_x; py_a = va.pixel_y; phs_a = va.hsync; pvs_a = va.vsync;
        px_b = vb.pixel_x; py_b = vb.pixel_y; phs_b = vb.hsync; pvs_b = vb.vsync;
    endtask

    initial begin
        int hs_low;
        int lt_cnt;
        int ft_cnt;
        int hs_first_x;
        int von_first_x;
        logic prev_hs;
        logic prev_von;

        #2 rst_a = 1'b1;
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Release on a falling edge; the next rising edge is edge 1.
        rst_a = 1'b0;
        rst_b = 1'b0;
        ft_cnt = 0;
        tick();
        tick();
        chk1("a_no_ptick_edge2", va.p_tick, 1'b0);
        tick();
        chk1("a_first_ptick", va.p_tick, 1'b1);
        chk10("a_first_pixel_held", va.pixel_x, 10'd0);
        tick();
        chk1("a_ptick_drop", va.p_tick, 1'b0);
        chk10("a_x_advance", va.pixel_x, 10'd1);

        while (na < 3200) begin
            tick();
            if (nb <= 588 && vb.frame_tick) ft_cnt++;
        end
        chk_int("b_three_frames", ft_cnt, 3);

        // One full line of the default geometry, starting at pixel (0,1).
        hs_low = 0; lt_cnt = 0; hs_first_x = -1; von_first_x = -1;
        prev_hs = va.hsync; prev_von = va.video_on;
        for (int i = 0; i < 3200; i++) begin
            tick();
            if (!va.hsync) hs_low++;
            if (va.line_tick) lt_cnt++;
            if (prev_hs && !va.hsync) hs_first_x = int'(va.pixel_x);
            if (prev_von && !va.video_on) von_first_x = int'(va.pixel_x);
            prev_hs = va.hsync;
            prev_von = va.video_on;
        end
        chk_int("a_hsync_low_clks", hs_low, 384);
        chk_int("a_line_ticks", lt_cnt, 1);
        chk_int("a_hsync_start_x", hs_first_x, 656);
        chk_int("a_von_end_x", von_first_x, 640);

        // Asynchronous resets at random raster points.
        for (int r = 0; r < 4; r++) begin
            int run = int'($urandom_range(100, 1500));
            for (int i = 0; i < run; i++) tick();
            #2;
            rst_a = 1'b1;
            rst_b = 1'b1;
            #1;
            na = 0;
            nb = 0;
            prev_ok_a = 1'b0;
            prev_ok_b = 1'b0;
            check_a("async");
            check_b("async");
            run = int'($urandom_range(1, 4));
            for (int i = 0; i < run; i++) tick();
            rst_a = 1'b0;
            if (($urandom & 1) == 1) rst_b = 1'b0;
            run = int'($urandom_range(200, 2000));
            for (int i = 0; i < run; i++) begin
                tick();
                if (i == 5) rst_b = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
